// File: rtl/ascon_pack.sv
// Shared ASCON-AEAD128 definitions: state type, widths, IV and round constants.
package ascon_pack;

  localparam int STATE_WORDS = 5;
  localparam int WORD_W      = 64;
  localparam int RATE_W      = 128;
  localparam int MAX_ROUNDS  = 16;

  typedef logic [WORD_W-1:0] type_state [0:STATE_WORDS-1];

  localparam logic [WORD_W-1:0] ASCON_AEAD128_IV = 64'h0000_1000_808c_0001;

  // Constant added to S2 in round i of a p[rnd] permutation; the table is
  // indexed from the end so that p[12] and p[8] share the same tail.
  function automatic logic [WORD_W-1:0] round_const(input int unsigned rnd, input int unsigned i);
    logic [7:0] c;
    unique case (MAX_ROUNDS - rnd + i)
      0:  c = 8'h3c;
      1:  c = 8'h2d;
      2:  c = 8'h1e;
      3:  c = 8'h0f;
      4:  c = 8'hf0;
      5:  c = 8'he1;
      6:  c = 8'hd2;
      7:  c = 8'hc3;
      8:  c = 8'hb4;
      9:  c = 8'ha5;
      10: c = 8'h96;
      11: c = 8'h87;
      12: c = 8'h78;
      13: c = 8'h69;
      14: c = 8'h5a;
      15: c = 8'h4b;
      default: c = 8'h00;
    endcase
    return {56'h0, c};
  endfunction

endpackage

// File: rtl/xor_begin.sv
// Rate-absorption XOR stage: folds a 128-bit block into S0/S1 and registers
// the full state toward the permutation input mux.
module xor_begin
  import ascon_pack::*;
(
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic [RATE_W-1:0] data_i,
  input  logic              enable_xb_i,
  input  type_state         state_i,
  output type_state         output_mux_o
);

  type_state next_state;

  always_comb begin
    // NOTE: assign the whole result first so every path drives every word; no latch.
    next_state = state_i;
    if (enable_xb_i) begin
      next_state[0] = state_i[0] ^ data_i[WORD_W-1:0];
      next_state[1] = state_i[1] ^ data_i[RATE_W-1:WORD_W];
    end
  end

  // NOTE: non-blocking for the state register; reset clears it without waiting for a clock.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      output_mux_o <= '{default: '0};
    end else begin
      output_mux_o <= next_state;
    end
  end

endmodule

// File: tb/tb_xor_begin.sv
// Directed self-checking bench for xor_begin: reset, absorb, pass-through,
// capacity isolation, streaming and reset mid-stream.
module tb_xor_begin;
  import ascon_pack::*;

  logic             clock_i;
  logic             resetb_i;
  logic [127:0]     data_i;
  logic             enable_xb_i;
  type_state        state_i;
  type_state        output_mux_o;

  int n_vec;
  int n_err;

  xor_begin dut (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .data_i       (data_i),
    .enable_xb_i  (enable_xb_i),
    .state_i      (state_i),
    .output_mux_o (output_mux_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic check_word(input string tag, input int idx,
                            input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s S%0d: observed %h expected %h", tag, idx, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input type_state expected);
    for (int i = 0; i < STATE_WORDS; i++) check_word(tag, i, output_mux_o[i], expected[i]);
  endtask

  // Rising edge, then settle 1 time unit so sampling and driving sit away from it.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  type_state zero_s, st_a, exp_a, ones_exp;
  type_state st_stream [0:3];
  type_state exp_stream [0:3];
  logic [127:0] d_stream [0:3];
  logic         en_stream [0:3];

  initial begin
    n_vec = 0;
    n_err = 0;
    zero_s = '{default: 64'h0};
    st_a = '{64'h82bf91294ba5808d, 64'hd81eeca694136f8a, 64'h0217bc9ebd9fff02,
             64'h2163c2a59353d4c8, 64'h2731cda0e76aa05b};
    exp_a = '{64'hedcbb14c28cceccc, 64'hd81eeca6f67c2daa, 64'h0217bc9ebd9fff02,
              64'h2163c2a59353d4c8, 64'h2731cda0e76aa05b};
    ones_exp = '{64'hffffffffffffffff, 64'hffffffffffffffff, 64'h0, 64'h0, 64'h0};

    // Streaming vectors with hand-computed results.
    d_stream[0] = {64'h00000000000000f0, 64'h000000000000000f};
    st_stream[0] = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
    en_stream[0] = 1'b1;
    exp_stream[0] = '{64'he, 64'hf2, 64'h3, 64'h4, 64'h5};
    d_stream[1] = {64'haaaaaaaaaaaaaaaa, 64'h5555555555555555};
    st_stream[1] = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50};
    en_stream[1] = 1'b0;
    exp_stream[1] = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50};
    d_stream[2] = {64'h8000000000000000, 64'h0000000000000001};
    st_stream[2] = '{64'h8000000000000001, 64'h8000000000000001, 64'hdead, 64'hbeef, 64'hcafe};
    en_stream[2] = 1'b1;
    exp_stream[2] = '{64'h8000000000000000, 64'h0000000000000001, 64'hdead, 64'hbeef, 64'hcafe};
    d_stream[3] = {64'hffffffffffffffff, 64'hffffffffffffffff};
    st_stream[3] = '{64'h0123456789abcdef, 64'hfedcba9876543210, 64'h7, 64'h8, 64'h9};
    en_stream[3] = 1'b0;
    exp_stream[3] = '{64'h0123456789abcdef, 64'hfedcba9876543210, 64'h7, 64'h8, 64'h9};

    // Reset asserted with live inputs: output zero, even across an edge.
    resetb_i    = 1'b0;
    enable_xb_i = 1'b1;
    data_i      = 128'h0000626F42206F74206563696C41;
    state_i     = st_a;
    #2;
    check_state("reset_initial", zero_s);
    step();
    check_state("reset_hold_edge", zero_s);

    // Release between edges: still zero until the next rising edge.
    resetb_i = 1'b1;
    #1;
    check_state("release_no_edge", zero_s);

    step();
    check_state("absorb", exp_a);

    enable_xb_i = 1'b0;
    step();
    check_state("pass_through", st_a);

    enable_xb_i = 1'b1;
    data_i      = '1;
    state_i     = zero_s;
    step();
    check_state("capacity_iso", ones_exp);

    for (int k = 0; k < 4; k++) begin
      enable_xb_i = en_stream[k];
      data_i      = d_stream[k];
      state_i     = st_stream[k];
      step();
      check_state($sformatf("stream_%0d", k), exp_stream[k]);
    end

    // Reset mid-stream, between edges: clears immediately.
    enable_xb_i = 1'b1;
    data_i      = d_stream[0];
    state_i     = st_stream[0];
    #2;
    resetb_i = 1'b0;
    #1;
    check_state("reset_mid_stream", zero_s);
    step();
    check_state("reset_mid_hold", zero_s);
    resetb_i = 1'b1;
    #1;
    check_state("release_mid_no_edge", zero_s);
    step();
    check_state("resume", exp_stream[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
